// File: rtl/card_hand_display.sv
// rtl/card_hand_display.sv - baccarat card hand holder with seven-segment display and newest-card blink
module card_hand_display #(
  parameter int NSLOTS       = 3,
  parameter int BLINK_CYCLES = 4
) (
  input  logic                  slow_clock,
  input  logic                  resetb,
  input  logic                  load,
  input  logic [3:0]            card,
  input  logic                  clear,
  input  logic                  blink_en,
  output logic [7*NSLOTS-1:0]   HEX,
  output logic [3:0]            score,
  output logic [2:0]            count,
  output logic                  full,
  output logic                  err
);

  localparam int CW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  logic [3:0]    slots [NSLOTS];
  logic [CW-1:0] blink_cnt;
  logic          phase_on;
  logic          card_valid;
  logic          accept;
  logic [3:0]    card_value;
  logic [4:0]    score_sum;
  logic [3:0]    score_next;

  // Active-low segment pattern (g..a) for a card code; code 0 is an empty slot.
  function automatic logic [6:0] seg_decode(input logic [3:0] c);
    case (c)
      4'd1:    seg_decode = 7'b0001000;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      4'd10:   seg_decode = 7'b1000000;
      4'd11:   seg_decode = 7'b1100001;
      4'd12:   seg_decode = 7'b0011000;
      4'd13:   seg_decode = 7'b0001001;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  assign full       = (count == 3'(NSLOTS));
  assign card_valid = (card >= 4'd1) && (card <= 4'd13);
  assign accept     = load && card_valid && !full;

  // Baccarat value: face cards and tens count zero; score wraps modulo 10.
  always_comb begin
    card_value = (card <= 4'd9) ? card : 4'd0;
    score_sum  = {1'b0, score} + {1'b0, card_value};
    score_next = (score_sum >= 5'd10) ? 4'(score_sum - 5'd10) : score_sum[3:0];
  end

  // Hand state, rejected-load flag and free-running blink timer.
  always_ff @(posedge slow_clock) begin
    if (!resetb || clear) begin
      for (int i = 0; i < NSLOTS; i++) slots[i] <= 4'd0;
      count     <= 3'd0;
      score     <= 4'd0;
      err       <= 1'b0;
      blink_cnt <= '0;
      phase_on  <= 1'b1;
    end else begin
      err <= load && !accept;
      if (accept) begin
        for (int i = 0; i < NSLOTS; i++) begin
          if (count == 3'(i)) slots[i] <= card;
        end
        count     <= count + 3'd1;
        score     <= score_next;
        blink_cnt <= '0;
        phase_on  <= 1'b1;
      end else if (blink_cnt == CW'(BLINK_CYCLES - 1)) begin
        blink_cnt <= '0;
        phase_on  <= ~phase_on;
      end else begin
        blink_cnt <= blink_cnt + CW'(1);
      end
    end
  end

  // Segment drive; the newest card goes dark during the off phase when blinking.
  always_comb begin
    HEX = '1;
    for (int i = 0; i < NSLOTS; i++) begin
      if (3'(i) < count) begin
        if (blink_en && !phase_on && (3'(i) == count - 3'd1))
          HEX[7*i +: 7] = 7'b1111111;
        else
          HEX[7*i +: 7] = seg_decode(slots[i]);
      end
    end
  end

endmodule

// File: tb/tb_card_hand_display.sv
// tb/tb_card_hand_display.sv - directed self-checking bench for card_hand_display
module tb_card_hand_display;

  logic        slow_clock = 1'b0;
  logic        resetb = 1'b0;
  logic        load = 1'b0;
  logic [3:0]  card = 4'd0;
  logic        clear = 1'b0;
  logic        blink_en = 1'b0;
  logic [20:0] HEX;
  logic [3:0]  score;
  logic [2:0]  count;
  logic        full;
  logic        err;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] S_OFF = 7'b1111111;

  card_hand_display #(.NSLOTS(3), .BLINK_CYCLES(4)) dut (
    .slow_clock(slow_clock),
    .resetb(resetb),
    .load(load),
    .card(card),
    .clear(clear),
    .blink_en(blink_en),
    .HEX(HEX),
    .score(score),
    .count(count),
    .full(full),
    .err(err)
  );

  always #5 slow_clock = ~slow_clock;

  task automatic tick();
    @(posedge slow_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_card(input logic [3:0] c);
    load = 1'b1;
    card = c;
    tick();
    load = 1'b0;
    card = 4'd0;
  endtask

  initial begin
    // Reset state
    resetb = 1'b0;
    tick();
    check("rst_hex", 32'(HEX), 32'h1FFFFF);
    check("rst_count", 32'(count), 0);
    check("rst_score", 32'(score), 0);
    check("rst_full", 32'(full), 0);
    check("rst_err", 32'(err), 0);
    resetb = 1'b1;

    // A, K, 9 fill the hand
    load_card(4'd1);
    check("a_slot0", 32'(HEX[6:0]), 32'b0001000);
    check("a_slot1", 32'(HEX[13:7]), 32'(S_OFF));
    check("a_score", 32'(score), 1);
    check("a_count", 32'(count), 1);
    load_card(4'd13);
    load_card(4'd9);
    check("full_hex", 32'(HEX), 32'({7'b0010000, 7'b0001001, 7'b0001000}));
    check("full_score", 32'(score), 0);
    check("full_count", 32'(count), 3);
    check("full_full", 32'(full), 1);
    check("full_err", 32'(err), 0);

    // Load into a full hand is rejected with a single err pulse
    load_card(4'd5);
    check("ovf_err", 32'(err), 1);
    check("ovf_hex", 32'(HEX), 32'({7'b0010000, 7'b0001001, 7'b0001000}));
    check("ovf_count", 32'(count), 3);
    check("ovf_score", 32'(score), 0);
    tick();
    check("ovf_err_drop", 32'(err), 0);

    // Clear empties the hand
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_hex", 32'(HEX), 32'h1FFFFF);
    check("clr_count", 32'(count), 0);
    check("clr_score", 32'(score), 0);
    check("clr_full", 32'(full), 0);

    // Invalid codes 0 and 15 each give one err pulse
    load_card(4'd0);
    check("inv0_err", 32'(err), 1);
    check("inv0_count", 32'(count), 0);
    tick();
    check("inv0_err_drop", 32'(err), 0);
    load_card(4'd15);
    check("inv15_err", 32'(err), 1);
    check("inv15_count", 32'(count), 0);
    check("inv15_hex", 32'(HEX), 32'h1FFFFF);
    tick();
    check("inv15_err_drop", 32'(err), 0);

    // Ten, J, Q decode and score zero
    load_card(4'd10);
    load_card(4'd11);
    load_card(4'd12);
    check("tjq_hex", 32'(HEX), 32'({7'b0011000, 7'b1100001, 7'b1000000}));
    check("tjq_score", 32'(score), 0);

    // Clear wins over simultaneous load, no err
    clear = 1'b1;
    tick();
    clear = 1'b0;
    load_card(4'd4);
    check("pre_cl_score", 32'(score), 4);
    clear = 1'b1;
    load = 1'b1;
    card = 4'd3;
    tick();
    clear = 1'b0;
    load = 1'b0;
    check("cl_ld_count", 32'(count), 0);
    check("cl_ld_score", 32'(score), 0);
    check("cl_ld_err", 32'(err), 0);
    tick();
    check("cl_ld_err_next", 32'(err), 0);

    // Blink a single 7: four cycles on, four off, repeating
    blink_en = 1'b1;
    load_card(4'd7);
    for (int k = 0; k < 16; k++) begin
      check($sformatf("blink_slot0_k%0d", k), 32'(HEX[6:0]),
            (((k / 4) % 2) == 0) ? 32'b1111000 : 32'(S_OFF));
      check($sformatf("blink_slot1_k%0d", k), 32'(HEX[13:7]), 32'(S_OFF));
      tick();
    end
    // Now at k=16: off phase would be k=20; disabling blink shows steadily
    tick(); tick(); tick(); tick();
    blink_en = 1'b0;
    #1;
    check("blink_dis_steady", 32'(HEX[6:0]), 32'b1111000);

    // 8 + 6 -> score 4, then reset over a simultaneous load
    clear = 1'b1;
    tick();
    clear = 1'b0;
    load_card(4'd8);
    load_card(4'd6);
    check("86_score", 32'(score), 4);
    check("86_count", 32'(count), 2);
    check("86_hex", 32'(HEX), 32'({S_OFF, 7'b0000010, 7'b0000000}));
    resetb = 1'b0;
    load = 1'b1;
    card = 4'd2;
    tick();
    resetb = 1'b1;
    load = 1'b0;
    check("rst2_hex", 32'(HEX), 32'h1FFFFF);
    check("rst2_count", 32'(count), 0);
    check("rst2_score", 32'(score), 0);
    check("rst2_full", 32'(full), 0);
    check("rst2_err", 32'(err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/card_hand_display.md
CARD_HAND_DISPLAY -- requirements
Module: card_hand_display

Interface
REQ-001 Parameter NSLOTS, default 3, SHALL give the number of card slots/HEX digits held, legal range 1..6.
REQ-002 Parameter BLINK_CYCLES, default 4, SHALL give the clock cycles per blink phase (on or off), legal range >=1.
REQ-003 Clocking SHALL be one clock; reset SHALL be synchronous and active-low.
REQ-004 slow_clock  in  1  SHALL be the sole clock; all state SHALL update on its rising edge.
REQ-005 resetb  in  1  SHALL be the synchronous active-low reset.
REQ-006 load  in  1  SHALL be a one-cycle request to append card to the hand.
REQ-007 card  in  4  SHALL be the card code: 1=A, 2..9, 10, 11=J, 12=Q, 13=K; 0/14/15 invalid.
REQ-008 clear  in  1  SHALL empty the hand.
REQ-009 blink_en  in  1  SHALL enable blinking of the newest card.
REQ-010 HEX  out  7*NSLOTS  SHALL drive active-low segments, slot i on HEX[7*i+6:7*i], bit order g..a.
REQ-011 score  out  4  SHALL give the baccarat hand value, 0..9.
REQ-012 count  out  3  SHALL give the number of filled slots, 0..NSLOTS.
REQ-013 full  out  1  SHALL be high when count==NSLOTS.
REQ-014 err  out  1  SHALL pulse high one cycle for each rejected load.

Function
REQ-015 An accepted load SHALL write card into slot index count, increment count, and update score, all on the same edge.
REQ-016 A load SHALL be accepted only when card is valid, full is low, and clear is low.
REQ-017 A load with invalid card or with full high SHALL leave all slots, count and score unchanged, and SHALL assert err on the following cycle for one cycle.
REQ-018 clear SHALL reset all slots to empty, count and score to 0, and the blink state; clear SHALL override a simultaneous load with no err.
REQ-019 Card value SHALL be A=1, 2..9 face value, and 10/J/Q/K=0; score SHALL equal (previous score + value) mod 10.
REQ-020 HEX SHALL be combinational from registered state, so a card SHALL be visible in the cycle after the accepting edge.
REQ-021 An empty slot SHALL display 1111111.
REQ-022 Filled slots SHALL display A=0001000, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, 10=1000000, J=1100001, Q=0011000, K=0001001.
REQ-023 The blink counter SHALL count 0..BLINK_CYCLES-1 and wrap to 0, toggling phase (on/off) at each wrap.
REQ-024 Each accepted load SHALL reset the counter to 0 and set phase on.
REQ-025 When blink_en is high, count>0, and phase is off, slot count-1 SHALL display 1111111; all other slots SHALL be unaffected.
REQ-026 When blink_en is low, all filled slots SHALL display steadily; the counter SHALL keep running.
REQ-027 full SHALL be derived combinationally from count.

Reset
REQ-028 When resetb is low at an edge, all slots SHALL be empty, count=0, score=0, err=0, counter=0, and phase on; HEX SHALL show all 1111111.
REQ-029 Reset SHALL override a simultaneous clear or load, including mid-blink and mid-hand.

Verification
REQ-030 The bench SHALL cover: reset, then load card=1, card=13, card=9 (NSLOTS=3) -> HEX slot0=0001000, slot1=0001001, slot2=0010000, score=0, count=3, full=1.
REQ-031 The bench SHALL cover: full hand, then load card=5 -> slots unchanged and err high exactly one cycle.
REQ-032 The bench SHALL cover: load card=0, then card=15 -> count stays 0 and two err pulses.
REQ-033 The bench SHALL cover: blink_en=1, BLINK_CYCLES=4, one card=7 loaded -> slot0 shows 1111000 for 4 cycles, then 1111111 for 4 cycles, repeating.
REQ-034 The bench SHALL cover: clear and load asserted together -> count=0, score=0, err=0.
REQ-035 The bench SHALL cover: cards 8 and 6 loaded -> score=4; then resetb low for one cycle -> all outputs return to reset values.
